// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park gate controllers.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_OPEN_ENT  = 2'd1,
        ST_OPEN_EXIT = 2'd2,
        ST_CLOSE     = 2'd3
    } gate_state_e;

    localparam int unsigned DEF_CAPACITY     = 8;
    localparam int unsigned DEF_OPEN_TIMEOUT = 16;
    localparam int unsigned DEF_CLOSE_HOLD   = 4;

    // Per-lane access codes checked by the lane password controllers (lane 0 in the low slice).
    localparam int unsigned PW_W = 16;
    localparam logic [4*PW_W-1:0] LANE_PASSWORDS = {16'h7391, 16'h4C2E, 16'h0A5D, 16'h1234};

    function automatic logic password_ok(input logic [1:0] lane, input logic [PW_W-1:0] code);
        return code == LANE_PASSWORDS[32'(lane)*PW_W +: PW_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin lane picker: first requester searching upward from last+1, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [1:0]           last_i,
    output logic [NUM_LANES-1:0] grant_oh_c,
    output logic [1:0]           grant_idx_c
);

    logic found;

    always_comb begin
        grant_oh_c  = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            for (int j = 0; j < int'(NUM_LANES); j++) begin
                if (!found && req_i[j] &&
                    (j == ((int'(last_i) + 1 + k) % int'(NUM_LANES)))) begin
                    found         = 1'b1;
                    grant_oh_c[j] = 1'b1;
                    grant_idx_c   = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Grants entry/exit barriers one at a time and tracks car-park occupancy.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 2,
    parameter int unsigned CAPACITY     = DEF_CAPACITY,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
    parameter int unsigned CLOSE_HOLD   = DEF_CLOSE_HOLD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] ent_req,
    input  logic [NUM_LANES-1:0] ent_pass,
    input  logic                 exit_req,
    input  logic                 exit_pass,
    output logic [NUM_LANES-1:0] gate_open,
    output logic                 exit_open,
    output logic [1:0]           grant_lane,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 full,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned TMR_W = (OPEN_TIMEOUT > 1) ? $clog2(OPEN_TIMEOUT) : 1;

    gate_state_e            state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       occ_q, occ_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             last_q, last_d;
    logic [NUM_LANES-1:0]   grant_oh_q, grant_oh_d;
    logic [NUM_LANES-1:0]   gate_open_q, gate_open_d;
    logic                   exit_open_q, exit_open_d;
    logic                   full_q, full_d;
    logic                   busy_q, busy_d;
    logic                   tmo_q, tmo_d;

    logic [NUM_LANES-1:0]   arb_oh;
    logic [1:0]             arb_idx;

    rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr (
        .req_i       (ent_req),
        .last_i      (last_q),
        .grant_oh_c  (arb_oh),
        .grant_idx_c (arb_idx)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            occ_q       <= '0;
            grant_q     <= '0;
            last_q      <= 2'(NUM_LANES - 1);
            grant_oh_q  <= '0;
            gate_open_q <= '0;
            exit_open_q <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            grant_oh_q  <= grant_oh_d;
            gate_open_q <= gate_open_d;
            exit_open_q <= exit_open_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state, timer, occupancy and output decode from the next state.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        occ_d      = occ_q;
        grant_d    = grant_q;
        last_d     = last_q;
        grant_oh_d = grant_oh_q;
        tmo_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exit_req) begin
                    state_d = ST_OPEN_EXIT;
                    timer_d = '0;
                end else if ((|ent_req) && !full_q) begin
                    state_d    = ST_OPEN_ENT;
                    timer_d    = '0;
                    grant_d    = arb_idx;
                    last_d     = arb_idx;
                    grant_oh_d = arb_oh;
                end
            end
            ST_OPEN_ENT: begin
                // A pass in the final open cycle beats the timeout.
                if (|(ent_pass & grant_oh_q)) begin
                    occ_d   = occ_q + CNT_W'(1);
                    timer_d = '0;
                    state_d = ST_CLOSE;
                end else if (timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_CLOSE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_OPEN_EXIT: begin
                if (exit_pass) begin
                    occ_d   = (occ_q == '0) ? '0 : occ_q - CNT_W'(1);
                    timer_d = '0;
                    state_d = ST_CLOSE;
                end else if (timer_q == TMR_W'(OPEN_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_CLOSE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CLOSE: begin
                if (timer_q == TMR_W'(CLOSE_HOLD - 1)) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        gate_open_d = (state_d == ST_OPEN_ENT) ? grant_oh_d : '0;
        exit_open_d = (state_d == ST_OPEN_EXIT);
        full_d      = (occ_d == CNT_W'(CAPACITY));
        busy_d      = (state_d != ST_IDLE);
    end

    assign gate_open   = gate_open_q;
    assign exit_open   = exit_open_q;
    assign grant_lane  = grant_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule
